// File: rtl/matrix_applications_if.sv
// Bundle of the start strobe and the three units' data/handshake signals.
// master : the surrounding system (drives start, operands and *_valid_in)
// slave  : matrix_applications (drives results, *_valid, *_done, filt_ready)
interface matrix_applications_if #(
   parameter int P          = 3,
   parameter int DATA_WIDTH = 8
);
   localparam int W2   = 2 * DATA_WIDTH;
   localparam int BA_W = (P > 1) ? $clog2(P) : 1;

   logic                         start;
   // neural
   logic [1:0]                   act_type;
   logic signed [DATA_WIDTH-1:0] bias_in;
   logic                         bias_wen;
   logic [BA_W-1:0]              bias_addr;
   logic signed [W2-1:0]         nn_result;
   logic                         nn_valid_in;
   logic [W2-1:0]                nn_out;
   logic                         nn_valid;
   logic                         nn_done;
   // filter
   logic signed [DATA_WIDTH-1:0] kernel_in;
   logic [3:0]                   kernel_addr;
   logic                         kernel_wen;
   logic [DATA_WIDTH-1:0]        pixel_in;
   logic                         pixel_valid;
   logic [9*DATA_WIDTH-1:0]      filt_window;
   logic                         filt_ready;
   logic signed [W2-1:0]         filt_result;
   logic                         filt_valid_in;
   logic [W2-1:0]                filt_out;
   logic                         filt_valid;
   logic                         filt_done;
   // transform
   logic [DATA_WIDTH-1:0]        x_in;
   logic [DATA_WIDTH-1:0]        y_in;
   logic [1:0]                   tr_type;
   logic [DATA_WIDTH-1:0]        param1;
   logic [DATA_WIDTH-1:0]        param2;
   logic signed [W2-1:0]         tr_result;
   logic                         tr_valid_in;
   logic signed [DATA_WIDTH-1:0] x_out;
   logic signed [DATA_WIDTH-1:0] y_out;
   logic [W2-1:0]                combined_out;
   logic                         tr_valid;
   logic                         tr_done;

   modport master (
      output start, act_type, bias_in, bias_wen, bias_addr, nn_result, nn_valid_in,
             kernel_in, kernel_addr, kernel_wen, pixel_in, pixel_valid,
             filt_result, filt_valid_in,
             x_in, y_in, tr_type, param1, param2, tr_result, tr_valid_in,
      input  nn_out, nn_valid, nn_done, filt_window, filt_ready, filt_out,
             filt_valid, filt_done, x_out, y_out, combined_out, tr_valid, tr_done
   );

   modport slave (
      input  start, act_type, bias_in, bias_wen, bias_addr, nn_result, nn_valid_in,
             kernel_in, kernel_addr, kernel_wen, pixel_in, pixel_valid,
             filt_result, filt_valid_in,
             x_in, y_in, tr_type, param1, param2, tr_result, tr_valid_in,
      output nn_out, nn_valid, nn_done, filt_window, filt_ready, filt_out,
             filt_valid, filt_done, x_out, y_out, combined_out, tr_valid, tr_done
   );
endinterface

// File: rtl/matrix_applications.sv
// Post-processing for a matrix engine: three independent units armed by a
// shared start pulse.
//   neural    : bias add (column-indexed) + activation on nn_result words
//   filter    : 3x3 pixel window via two line buffers, |filt_result| clipped to 255
//   transform : captures two tr_result words as saturated (x', y') coordinates
// Ports: clk, rst (async, active-high), bus (matrix_applications_if.slave).
module matrix_applications #(
   parameter int M          = 3,
   parameter int P          = 3,
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 3
)(
   input  logic                 clk,
   input  logic                 rst,
   matrix_applications_if.slave bus
);
   localparam int W2   = 2 * DATA_WIDTH;
   localparam int BA_W = (P > 1) ? $clog2(P) : 1;
   localparam int EL_W = $clog2(M * P + 1);
   localparam int THR  = 2 * IMG_W + 3;
   localparam int PC_W = $clog2(THR + 1);
   localparam logic [EL_W-1:0]      LAST_EL  = EL_W'(M * P - 1);
   localparam logic [BA_W-1:0]      LAST_COL = BA_W'(P - 1);
   localparam logic [PC_W-1:0]      PIX_THR  = PC_W'(THR);
   localparam logic signed [W2-1:0] SMAX     = (W2'(1) <<< (DATA_WIDTH - 1)) - W2'(1);
   localparam logic signed [W2-1:0] SMIN     = ~SMAX;

   typedef enum logic {U_IDLE, U_RUN} unit_e;
   typedef enum logic [1:0] {T_IDLE, T_X, T_Y, T_OUT} tr_e;

   function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [W2-1:0] v);
      if (v > SMAX)      return SMAX[DATA_WIDTH-1:0];
      else if (v < SMIN) return SMIN[DATA_WIDTH-1:0];
      else               return v[DATA_WIDTH-1:0];
   endfunction

   function automatic logic signed [W2-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
      return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
   endfunction

   function automatic logic signed [W2-1:0] activate(input logic signed [W2-1:0] s,
                                                     input logic [1:0] t);
      case (t)
         2'b00:   return (s < 0) ? '0 : s;
         2'b01:   return s;
         2'b10:   return (s < 0) ? (s >>> 3) : s;
         default: return sext(sat_dw(s));
      endcase
   endfunction

   // Widened by one bit so |most-negative| does not overflow before clipping.
   function automatic logic [W2-1:0] abs_sat(input logic signed [W2-1:0] v);
      logic signed [W2:0] e;
      e = (W2+1)'(v);
      if (e < 0) e = -e;
      if (e > 255) return W2'(255);
      return e[W2-1:0];
   endfunction

   // ---------------- neural unit ----------------
   unit_e                        nn_state_q, nn_state_d;
   logic [EL_W-1:0]              nn_elem_q;
   logic [BA_W-1:0]              nn_col_q;
   logic signed [DATA_WIDTH-1:0] bias_q [P];
   logic [W2-1:0]                nn_out_q;
   logic                         nn_vld_q;
   logic                         nn_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) nn_state_q <= U_IDLE;
      else     nn_state_q <= nn_state_d;
   end

   always_comb begin
      nn_state_d = nn_state_q;
      if (bus.start)                          nn_state_d = U_RUN;
      else if (nn_acc && nn_elem_q == LAST_EL) nn_state_d = U_IDLE;
   end

   always_comb begin
      nn_acc = (nn_state_q == U_RUN) && bus.nn_valid_in && !bus.start;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nn_elem_q <= '0;
         nn_col_q  <= '0;
         nn_out_q  <= '0;
         nn_vld_q  <= 1'b0;
         for (int i = 0; i < P; i++) bias_q[i] <= '0;
      end else begin
         nn_vld_q <= nn_acc;
         if (bus.start) begin
            nn_elem_q <= '0;
            nn_col_q  <= '0;
         end else if (nn_acc) begin
            nn_elem_q <= nn_elem_q + 1'b1;
            nn_col_q  <= (nn_col_q == LAST_COL) ? '0 : nn_col_q + 1'b1;
            nn_out_q  <= activate(bus.nn_result + sext(bias_q[nn_col_q]), bus.act_type);
         end
         // Out-of-range addresses (when P is not a power of two) are dropped.
         if (bus.bias_wen && ({1'b0, bus.bias_addr} < (BA_W+1)'(P)))
            bias_q[bus.bias_addr] <= bus.bias_in;
      end
   end

   assign bus.nn_out   = nn_out_q;
   assign bus.nn_valid = nn_vld_q;
   assign bus.nn_done  = nn_vld_q;

   // ---------------- filter unit ----------------
   unit_e                        f_state_q, f_state_d;
   logic [PC_W-1:0]              pix_cnt_q;
   logic [DATA_WIDTH-1:0]        lb0_q [IMG_W];
   logic [DATA_WIDTH-1:0]        lb1_q [IMG_W];
   // win_q[r*3+c]: row 0 is oldest line, column 2 is newest pixel of its row.
   logic [DATA_WIDTH-1:0]        win_q [9];
   logic signed [DATA_WIDTH-1:0] kernel_q [9];
   logic [W2-1:0]                filt_out_q;
   logic                         filt_vld_q;
   logic                         f_shift, f_acc, f_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) f_state_q <= U_IDLE;
      else     f_state_q <= f_state_d;
   end

   always_comb begin
      f_state_d = f_state_q;
      if (bus.start) f_state_d = U_RUN;
   end

   always_comb begin
      f_ready = (f_state_q == U_RUN) && (pix_cnt_q == PIX_THR);
      f_shift = (f_state_q == U_RUN) && bus.pixel_valid && !bus.start;
      f_acc   = f_ready && bus.filt_valid_in && !bus.start;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt_q  <= '0;
         filt_out_q <= '0;
         filt_vld_q <= 1'b0;
         for (int i = 0; i < IMG_W; i++) begin
            lb0_q[i] <= '0;
            lb1_q[i] <= '0;
         end
         for (int i = 0; i < 9; i++) begin
            win_q[i]    <= '0;
            kernel_q[i] <= '0;
         end
      end else begin
         filt_vld_q <= f_acc;
         if (bus.start) pix_cnt_q <= '0;
         else if (f_shift && pix_cnt_q != PIX_THR) pix_cnt_q <= pix_cnt_q + 1'b1;
         if (f_shift) begin
            lb0_q[0] <= bus.pixel_in;
            lb1_q[0] <= lb0_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
               lb0_q[i] <= lb0_q[i-1];
               lb1_q[i] <= lb1_q[i-1];
            end
            win_q[8] <= bus.pixel_in;
            win_q[5] <= lb0_q[IMG_W-1];
            win_q[2] <= lb1_q[IMG_W-1];
            for (int r = 0; r < 3; r++) begin
               win_q[r*3+1] <= win_q[r*3+2];
               win_q[r*3]   <= win_q[r*3+1];
            end
         end
         if (f_acc) filt_out_q <= abs_sat(bus.filt_result);
         if (bus.kernel_wen && bus.kernel_addr <= 4'd8)
            kernel_q[bus.kernel_addr] <= bus.kernel_in;
      end
   end

   always_comb begin
      bus.filt_window = '0;
      for (int i = 0; i < 9; i++) bus.filt_window[(8-i)*DATA_WIDTH +: DATA_WIDTH] = win_q[i];
   end

   assign bus.filt_ready = f_ready;
   assign bus.filt_out   = filt_out_q;
   assign bus.filt_valid = filt_vld_q;
   assign bus.filt_done  = filt_vld_q;

   // ---------------- transform unit ----------------
   tr_e                          t_state_q, t_state_d;
   logic signed [DATA_WIDTH-1:0] x_cap_q, y_cap_q, x_out_q, y_out_q;
   logic [DATA_WIDTH-1:0]        st_x_q, st_y_q, st_p1_q, st_p2_q;
   logic [1:0]                   st_type_q;
   logic                         tr_vld_q;
   logic                         t_cap_x, t_cap_y, t_emit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) t_state_q <= T_IDLE;
      else     t_state_q <= t_state_d;
   end

   always_comb begin
      t_state_d = t_state_q;
      if (bus.start) t_state_d = T_X;
      else begin
         case (t_state_q)
            T_X:     if (bus.tr_valid_in) t_state_d = T_Y;
            T_Y:     if (bus.tr_valid_in) t_state_d = T_OUT;
            T_OUT:   t_state_d = T_IDLE;
            default: t_state_d = T_IDLE;
         endcase
      end
   end

   always_comb begin
      t_cap_x = (t_state_q == T_X) && bus.tr_valid_in && !bus.start;
      t_cap_y = (t_state_q == T_Y) && bus.tr_valid_in && !bus.start;
      t_emit  = (t_state_q == T_OUT) && !bus.start;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_cap_q   <= '0;
         y_cap_q   <= '0;
         x_out_q   <= '0;
         y_out_q   <= '0;
         tr_vld_q  <= 1'b0;
         st_x_q    <= '0;
         st_y_q    <= '0;
         st_p1_q   <= '0;
         st_p2_q   <= '0;
         st_type_q <= '0;
      end else begin
         tr_vld_q <= t_emit;
         if (t_cap_x) x_cap_q <= sat_dw(bus.tr_result);
         if (t_cap_y) y_cap_q <= sat_dw(bus.tr_result);
         if (t_emit) begin
            x_out_q <= x_cap_q;
            y_out_q <= y_cap_q;
         end
         // Status snapshot only; the arithmetic never reads these.
         if (bus.start) begin
            st_x_q    <= bus.x_in;
            st_y_q    <= bus.y_in;
            st_p1_q   <= bus.param1;
            st_p2_q   <= bus.param2;
            st_type_q <= bus.tr_type;
         end
      end
   end

   assign bus.x_out        = x_out_q;
   assign bus.y_out        = y_out_q;
   assign bus.combined_out = {x_out_q, y_out_q};
   assign bus.tr_valid     = tr_vld_q;
   assign bus.tr_done      = tr_vld_q;
endmodule

// File: tb/tb_matrix_applications.sv
// Directed bench for matrix_applications (M=P=3, DATA_WIDTH=8, IMG_W=3).
module tb_matrix_applications;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   matrix_applications_if #(.P(3), .DATA_WIDTH(8)) bus ();

   matrix_applications #(.M(3), .P(3), .DATA_WIDTH(8), .IMG_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.start = 0; bus.act_type = 0; bus.bias_in = 0; bus.bias_wen = 0; bus.bias_addr = 0;
      bus.nn_result = 0; bus.nn_valid_in = 0;
      bus.kernel_in = 0; bus.kernel_addr = 0; bus.kernel_wen = 0;
      bus.pixel_in = 0; bus.pixel_valid = 0; bus.filt_result = 0; bus.filt_valid_in = 0;
      bus.x_in = 0; bus.y_in = 0; bus.tr_type = 0; bus.param1 = 0; bus.param2 = 0;
      bus.tr_result = 0; bus.tr_valid_in = 0;
      repeat (2) tick();

      check_val("rst_nn_out", bus.nn_out, 0);
      check_val("rst_nn_valid", bus.nn_valid, 0);
      check_val("rst_filt_ready", bus.filt_ready, 0);
      check_val("rst_filt_window", bus.filt_window, 0);
      check_val("rst_combined", bus.combined_out, 0);
      check_val("rst_tr_done", bus.tr_done, 0);
      rst = 1'b0;
      tick();

      // ReLU passthrough of a positive word
      pulse_start();
      bus.act_type = 2'b00; bus.nn_result = 16'h0050; bus.nn_valid_in = 1;
      tick();
      bus.nn_valid_in = 0;
      check_val("relu_pos", bus.nn_out, 16'd80);
      check_val("relu_done", bus.nn_done, 1);
      check_val("relu_valid", bus.nn_valid, 1);
      tick();
      check_val("relu_done_pulse", bus.nn_done, 0);

      // ReLU and leaky on a negative word
      pulse_start();
      bus.nn_result = 16'hFFB0; bus.nn_valid_in = 1;
      tick();
      check_val("relu_neg", bus.nn_out, 16'h0000);
      bus.act_type = 2'b10;
      tick();
      check_val("leaky_neg", bus.nn_out, 16'hFFF6);
      bus.nn_valid_in = 0;

      // bias per column, saturation, end of run after M*P elements
      bus.bias_addr = 1; bus.bias_in = 8'sd5; bus.bias_wen = 1;
      tick();
      bus.bias_wen = 0;
      pulse_start();
      bus.act_type = 2'b01; bus.nn_result = 16'd10; bus.nn_valid_in = 1;
      tick();
      check_val("bias_col0", bus.nn_out, 16'd10);
      tick();
      check_val("bias_col1", bus.nn_out, 16'd15);
      bus.act_type = 2'b11; bus.nn_result = 16'h0200;
      tick();
      check_val("sat_pos", bus.nn_out, 16'h007F);
      bus.nn_result = 16'hFE00;
      tick();
      check_val("sat_neg", bus.nn_out, 16'hFF80);
      bus.act_type = 2'b01; bus.nn_result = 16'd0;
      for (int j = 0; j < 5; j++) begin
         tick();
         check_val("run_elem_valid", bus.nn_valid, 1);
      end
      tick();
      check_val("idle_after_mp", bus.nn_valid, 0);
      bus.nn_valid_in = 0;

      // async reset in the middle of a neural run
      pulse_start();
      bus.nn_result = 16'd7; bus.nn_valid_in = 1;
      tick();
      check_val("pre_rst_out", bus.nn_out, 16'd7);
      #2 rst = 1'b1;
      #1;
      check_val("async_rst_out", bus.nn_out, 0);
      check_val("async_rst_valid", bus.nn_valid, 0);
      tick();
      rst = 1'b0;
      tick();
      check_val("post_rst_no_done", bus.nn_done, 0);
      check_val("post_rst_out", bus.nn_out, 0);
      bus.nn_valid_in = 0;
      pulse_start();
      bus.nn_result = 16'd10; bus.nn_valid_in = 1;
      tick();
      tick();
      check_val("bias_cleared", bus.nn_out, 16'd10);
      bus.nn_valid_in = 0;

      // filter
      pulse_start();
      bus.kernel_addr = 4'd3; bus.kernel_in = 8'sd2; bus.kernel_wen = 1;
      bus.filt_result = 16'h0042; bus.filt_valid_in = 1;
      tick();
      bus.kernel_addr = 4'd12;
      check_val("filt_not_ready_ignored", bus.filt_valid, 0);
      tick();
      bus.kernel_wen = 0; bus.filt_valid_in = 0;
      bus.pixel_valid = 1;
      for (int i = 0; i < 20; i++) begin
         bus.pixel_in = 8'(i + 1);
         tick();
         if (i == 7) check_val("ready_before_thr", bus.filt_ready, 0);
         if (i == 8) check_val("ready_at_thr", bus.filt_ready, 1);
      end
      bus.pixel_valid = 0;
      check_val("window", bus.filt_window, 72'h0C0D0E0F1011121314);
      bus.filt_result = 16'h0042; bus.filt_valid_in = 1;
      tick();
      check_val("filt_pos", bus.filt_out, 16'd66);
      check_val("filt_valid", bus.filt_valid, 1);
      check_val("filt_done", bus.filt_done, 1);
      bus.filt_result = 16'hFED4;
      tick();
      check_val("filt_neg_sat", bus.filt_out, 16'd255);
      bus.filt_result = 16'hFFFB;
      tick();
      check_val("filt_abs", bus.filt_out, 16'd5);
      bus.filt_valid_in = 0;
      tick();
      check_val("filt_valid_pulse", bus.filt_valid, 0);
      check_val("ready_held", bus.filt_ready, 1);
      pulse_start();
      check_val("ready_cleared_by_start", bus.filt_ready, 0);

      // transform
      bus.x_in = 8'd3; bus.y_in = 8'd4; bus.tr_type = 2'b01;
      pulse_start();
      bus.tr_result = 16'h0000; bus.tr_valid_in = 1;
      tick();
      bus.tr_result = 16'h000A;
      tick();
      bus.tr_valid_in = 0;
      check_val("tr_not_yet", bus.tr_valid, 0);
      tick();
      check_val("tr_x", $unsigned(bus.x_out), 8'h00);
      check_val("tr_y", $unsigned(bus.y_out), 8'h0A);
      check_val("tr_combined", bus.combined_out, 16'h000A);
      check_val("tr_valid", bus.tr_valid, 1);
      check_val("tr_done", bus.tr_done, 1);
      tick();
      check_val("tr_valid_pulse", bus.tr_valid, 0);
      pulse_start();
      bus.tr_result = 16'h0200; bus.tr_valid_in = 1;
      tick();
      bus.tr_result = 16'hFE00;
      tick();
      bus.tr_valid_in = 0;
      tick();
      check_val("tr_sat_x", $unsigned(bus.x_out), 8'h7F);
      check_val("tr_sat_y", $unsigned(bus.y_out), 8'h80);
      check_val("tr_sat_comb", bus.combined_out, 16'h7F80);
      bus.tr_result = 16'h0005; bus.tr_valid_in = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_val("tr_idle_ignored", bus.tr_valid, 0);
      end
      bus.tr_valid_in = 0;
      check_val("tr_idle_hold", $unsigned(bus.x_out), 8'h7F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
